pe_tile_scheduler: RTL and testbench
====================================

PE_TILE_SCHEDULER -- requirements
Module: pe_tile_scheduler

Interface
REQ-001 The block SHALL have parameter W_SIZE, default `W_SIZE, meaning the row/column coordinate width.
REQ-002 The block SHALL have parameter W_CHANNEL, default `W_CHANNEL, meaning the channel-tile index width.
REQ-003 The block SHALL have port clk  input  1  the single clock for all state.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port i_start  input  1  one-cycle request to begin a layer.
REQ-006 The block SHALL have port i_stall  input  1  while high, the scan is frozen.
REQ-007 The block SHALL have port cfg_rows, cfg_cols  input  W_SIZE  frame height and width.
REQ-008 The block SHALL have port cfg_q_chn, cfg_q_chn_out  input  W_CHANNEL  input and output channel tile counts.
REQ-009 The block SHALL have port pe_csync_done  input  1  PE filter-load acknowledge.
REQ-010 The block SHALL have port o_ctrl_csync_run  output  1  filter-sync request to the PE.
REQ-011 The block SHALL have port o_ctrl_data_run  output  1  valid pixel issue.
REQ-012 The block SHALL have port o_row, o_col  output  W_SIZE  current pixel.
REQ-013 The block SHALL have port o_chn, o_chn_out  output  W_CHANNEL  current tiles.
REQ-014 The block SHALL have port o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col  output  1  location flags.
REQ-015 The block SHALL have port o_busy  output  1  high outside IDLE.
REQ-016 The block SHALL have port o_done  output  1  one-cycle end-of-layer pulse.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, CSYNC, RUN and FIN.
REQ-018 In IDLE, i_start with all cfg fields nonzero SHALL latch the cfg values, zero all counters and enter CSYNC; i_start with any cfg field zero SHALL be ignored.
REQ-019 i_start SHALL be ignored in every state other than IDLE.
REQ-020 In CSYNC, o_ctrl_csync_run SHALL be high every cycle; the first cycle with pe_csync_done high SHALL move the FSM to RUN, and o_ctrl_csync_run SHALL drop in that same transition.
REQ-021 Each CSYNC entry SHALL hold o_ctrl_csync_run low for at least one cycle beforehand, so that the PE sees a rising edge.
REQ-022 In RUN with i_stall low, the block SHALL issue one pixel per cycle: o_ctrl_data_run high, with registered coordinates and flags aligned to that same cycle.
REQ-023 In RUN with i_stall high, o_ctrl_data_run SHALL be low and all counters SHALL hold.
REQ-024 The loop order SHALL be chn_out (outermost), then chn, then row, then col (innermost); col wraps at cfg_cols-1, and row wraps at cfg_rows-1.
REQ-025 After issuing pixel (cfg_rows-1, cfg_cols-1), the block SHALL advance chn, wrapping at cfg_q_chn-1 and on wrap advancing chn_out, and then: if the advance wrapped chn_out from cfg_q_chn_out-1, enter FIN; otherwise re-enter CSYNC.
REQ-026 FIN SHALL assert o_done for one cycle, then return to IDLE.
REQ-027 The location flags SHALL be: first_row = (row==0), last_row = (row==cfg_rows-1), first_col = (col==0), last_col = (col==cfg_cols-1). When a dimension is 1, its first and last flags SHALL both be high.
REQ-028 When o_ctrl_data_run is low, the outputs o_row/o_col/o_chn/o_chn_out SHALL hold the next pixel to be issued.
REQ-029 Counter comparisons SHALL use the latched cfg values only; cfg input changes during a layer SHALL have no effect.
REQ-030 If pe_csync_done is high while the FSM is outside CSYNC, it SHALL be ignored.
REQ-031 The total number of data_run cycles per layer SHALL equal cfg_rows*cfg_cols*cfg_q_chn*cfg_q_chn_out.

Reset
REQ-032 While rstn is low, the FSM SHALL be IDLE and all outputs and counters SHALL be 0.
REQ-033 A reset asserted mid-layer SHALL abort immediately, with no o_done pulse.

Structure
REQ-034 The state encoding localparams SHALL live in controller_params.vh, alongside the W_SIZE/W_CHANNEL macros.
REQ-035 One sub-module, tile_counter (a parameterised wrap counter with enable, limit input and wrap output), SHALL be instantiated four times: col, row, chn and chn_out.

Verification
REQ-036 The bench SHALL check: rows=3, cols=4, q_chn=2, q_chn_out=1, pe_csync_done returned 2 cycles after csync_run -> 2 CSYNC episodes, 24 data_run cycles, col sequence 0..3 repeating, o_done exactly once.
REQ-037 The bench SHALL check: rows=1, cols=1, q_chn=1, q_chn_out=1 -> one data_run cycle with all four location flags high, then o_done.
REQ-038 The bench SHALL check: i_stall high for 5 cycles mid-row at (1,2) -> data_run low for those 5 cycles, then resume at (1,2) with no pixel skipped or duplicated.
REQ-039 The bench SHALL check: i_start with cfg_cols=0 -> o_busy stays 0; i_start pulsed during RUN -> no restart, counts unchanged.
REQ-040 The bench SHALL check: rstn pulsed low during RUN of a 4x4x2x2 layer -> all outputs 0 asynchronously, no o_done; a later i_start completes a full layer of 64 pixels.
REQ-041 The bench SHALL check: pe_csync_done held high continuously -> each CSYNC lasts exactly 1 cycle, and csync_run is low for at least 1 cycle between episodes.

Source files
------------

// File: rtl/pe_tile_scheduler_pkg.sv
// Shared scheduler types: FSM state enum built on the encoding in controller_params.vh.
package pe_tile_scheduler_pkg;
`include "controller_params.vh"

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CSYNC = ST_CSYNC,
    RUN   = ST_RUN,
    FIN   = ST_FIN
  } state_t;
endpackage

// File: rtl/controller_params.vh
// Default coordinate/channel widths and the scheduler FSM state encoding.
`ifndef W_SIZE
`define W_SIZE 8
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 4
`endif

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_CSYNC = 2'd1;
localparam logic [1:0] ST_RUN   = 2'd2;
localparam logic [1:0] ST_FIN   = 2'd3;

// File: rtl/pe_tile_scheduler_counter.sv
// Wrap counter: counts 0..i_limit while enabled; o_wrap flags the enabled step that returns to 0.
module tile_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == i_limit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/pe_tile_scheduler.sv
// Layer scan scheduler: walks chn_out/chn/row/col, syncing PE filters before each channel tile.
// Counters always hold the next pixel to issue; data_run drops combinationally with i_stall.
module pe_tile_scheduler
  import pe_tile_scheduler_pkg::*;
#(
  parameter int W_SIZE    = `W_SIZE,
  parameter int W_CHANNEL = `W_CHANNEL
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic                 i_stall,
  input  logic [W_SIZE-1:0]    cfg_rows,
  input  logic [W_SIZE-1:0]    cfg_cols,
  input  logic [W_CHANNEL-1:0] cfg_q_chn,
  input  logic [W_CHANNEL-1:0] cfg_q_chn_out,
  input  logic                 pe_csync_done,
  output logic                 o_ctrl_csync_run,
  output logic                 o_ctrl_data_run,
  output logic [W_SIZE-1:0]    o_row,
  output logic [W_SIZE-1:0]    o_col,
  output logic [W_CHANNEL-1:0] o_chn,
  output logic [W_CHANNEL-1:0] o_chn_out,
  output logic                 o_is_first_row,
  output logic                 o_is_last_row,
  output logic                 o_is_first_col,
  output logic                 o_is_last_col,
  output logic                 o_busy,
  output logic                 o_done
);
  state_t               r_state;
  state_t               w_state_nxt;
  logic [W_SIZE-1:0]    r_rows_m1;
  logic [W_SIZE-1:0]    r_cols_m1;
  logic [W_CHANNEL-1:0] r_chn_m1;
  logic [W_CHANNEL-1:0] r_chn_out_m1;
  logic                 w_cfg_ok;
  logic                 w_launch;
  logic                 w_issue;
  logic                 w_wrap_col;
  logic                 w_wrap_row;
  logic                 w_wrap_chn;
  logic                 w_wrap_chn_out;

  assign w_cfg_ok = (|cfg_rows) && (|cfg_cols) && (|cfg_q_chn) && (|cfg_q_chn_out);
  assign w_launch = (r_state == IDLE) && i_start && w_cfg_ok;
  assign w_issue  = (r_state == RUN) && !i_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Limits are stored as count-1 so every counter compares against a register only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rows_m1    <= '0;
      r_cols_m1    <= '0;
      r_chn_m1     <= '0;
      r_chn_out_m1 <= '0;
    end else if (w_launch) begin
      r_rows_m1    <= cfg_rows - W_SIZE'(1);
      r_cols_m1    <= cfg_cols - W_SIZE'(1);
      r_chn_m1     <= cfg_q_chn - W_CHANNEL'(1);
      r_chn_out_m1 <= cfg_q_chn_out - W_CHANNEL'(1);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_ctrl_csync_run = 1'b0;
    o_ctrl_data_run  = 1'b0;
    o_busy           = 1'b1;
    o_done           = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_launch) w_state_nxt = CSYNC;
      end
      CSYNC: begin
        o_ctrl_csync_run = 1'b1;
        if (pe_csync_done) w_state_nxt = RUN;
      end
      RUN: begin
        o_ctrl_data_run = !i_stall;
        if (w_wrap_chn_out) begin
          w_state_nxt = FIN;
        end else if (w_wrap_row) begin
          w_state_nxt = CSYNC;
        end
      end
      FIN: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  tile_counter #(.W(W_SIZE)) u_col (
    .clk(clk), .rstn(rstn), .i_clr(w_launch), .i_en(w_issue),
    .i_limit(r_cols_m1), .o_cnt(o_col), .o_wrap(w_wrap_col)
  );

  tile_counter #(.W(W_SIZE)) u_row (
    .clk(clk), .rstn(rstn), .i_clr(w_launch), .i_en(w_wrap_col),
    .i_limit(r_rows_m1), .o_cnt(o_row), .o_wrap(w_wrap_row)
  );

  tile_counter #(.W(W_CHANNEL)) u_chn (
    .clk(clk), .rstn(rstn), .i_clr(w_launch), .i_en(w_wrap_row),
    .i_limit(r_chn_m1), .o_cnt(o_chn), .o_wrap(w_wrap_chn)
  );

  tile_counter #(.W(W_CHANNEL)) u_chn_out (
    .clk(clk), .rstn(rstn), .i_clr(w_launch), .i_en(w_wrap_chn),
    .i_limit(r_chn_out_m1), .o_cnt(o_chn_out), .o_wrap(w_wrap_chn_out)
  );

  // Flags are gated by busy so reset and IDLE present an all-zero output bus.
  assign o_is_first_row = o_busy && (o_row == '0);
  assign o_is_last_row  = o_busy && (o_row == r_rows_m1);
  assign o_is_first_col = o_busy && (o_col == '0);
  assign o_is_last_col  = o_busy && (o_col == r_cols_m1);
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Self-checking bench for pe_tile_scheduler: scoreboard of expected pixels plus per-scenario checks.
module tb_pe_tile_scheduler;
  localparam int WS = 8;
  localparam int WC = 4;

  typedef struct packed {
    logic [WS-1:0] row;
    logic [WS-1:0] col;
    logic [WC-1:0] chn;
    logic [WC-1:0] co;
    logic [3:0]    flags;
  } pix_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stall = 1'b0;
  logic [WS-1:0] cfg_rows = '0;
  logic [WS-1:0] cfg_cols = '0;
  logic [WC-1:0] cfg_q_chn = '0;
  logic [WC-1:0] cfg_q_chn_out = '0;
  logic          pe_csync_done = 1'b0;
  logic          o_ctrl_csync_run, o_ctrl_data_run;
  logic [WS-1:0] o_row, o_col;
  logic [WC-1:0] o_chn, o_chn_out;
  logic          o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
  logic          o_busy, o_done;

  int   errors = 0;
  int   checks = 0;
  int   n_pix = 0;
  int   n_csync_ep = 0;
  int   csync_len = 0;
  int   max_csync_len = 0;
  int   n_done = 0;
  int   csync_age = 0;
  logic prev_csync = 1'b0;
  bit   pe_hold = 1'b0;
  pix_t sb[$];
  pix_t exp_p;
  pix_t got_p;

  pe_tile_scheduler #(.W_SIZE(WS), .W_CHANNEL(WC)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_stall(i_stall),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_q_chn(cfg_q_chn),
    .cfg_q_chn_out(cfg_q_chn_out), .pe_csync_done(pe_csync_done),
    .o_ctrl_csync_run(o_ctrl_csync_run), .o_ctrl_data_run(o_ctrl_data_run),
    .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_chn_out(o_chn_out),
    .o_is_first_row(o_is_first_row), .o_is_last_row(o_is_last_row),
    .o_is_first_col(o_is_first_col), .o_is_last_col(o_is_last_col),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // PE model: acknowledges on the third csync cycle, or holds done high continuously.
  always @(negedge clk) begin
    if (o_ctrl_csync_run) csync_age = csync_age + 1;
    else csync_age = 0;
    pe_csync_done = pe_hold ? 1'b1 : (csync_age == 3);
  end

  // Scoreboard monitor: every issued pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_ctrl_data_run) begin
      n_pix = n_pix + 1;
      checks = checks + 1;
      got_p = '{o_row, o_col, o_chn, o_chn_out,
                {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col}};
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL pixel_extra: got r%0d c%0d ch%0d co%0d, expected no pixel",
                 o_row, o_col, o_chn, o_chn_out);
      end else begin
        exp_p = sb.pop_front();
        if (got_p !== exp_p)  begin
          errors = errors + 1;
          $display("FAIL pixel_seq: got r%0d c%0d ch%0d co%0d f%b, expected r%0d c%0d ch%0d co%0d f%b",
                   got_p.row, got_p.col, got_p.chn, got_p.co, got_p.flags,
                   exp_p.row, exp_p.col, exp_p.chn, exp_p.co, exp_p.flags);
        end
      end
    end
    if (o_ctrl_csync_run) begin
      if (!prev_csync) n_csync_ep = n_csync_ep + 1;
      csync_len = csync_len + 1;
      if (csync_len > max_csync_len) max_csync_len = csync_len;
    end else begin
      csync_len = 0;
    end
    prev_csync = o_ctrl_csync_run;
    if (o_done) n_done = n_done + 1;
  end

  task automatic push_layer(input int rows, input int cols, input int qc, input int qco);
    pix_t p;
    for (int co = 0; co < qco; co++)
      for (int ch = 0; ch < qc; ch++)
        for (int r = 0; r < rows; r++)
          for (int c = 0; c < cols; c++) begin
            p.row = WS'(r);
            p.col = WS'(c);
            p.chn = WC'(ch);
            p.co  = WC'(co);
            p.flags = {r == 0, r == rows - 1, c == 0, c == cols - 1};
            sb.push_back(p);
          end
  endtask

  task automatic clear_stats();
    n_pix = 0;
    n_csync_ep = 0;
    max_csync_len = 0;
    n_done = 0;
  endtask

  task automatic start_layer(input int rows, input int cols, input int qc, input int qco);
    clear_stats();
    push_layer(rows, cols, qc, qco);
    @(posedge clk); #1;
    cfg_rows = WS'(rows);
    cfg_cols = WS'(cols);
    cfg_q_chn = WC'(qc);
    cfg_q_chn_out = WC'(qco);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && n_done == 0; i++) @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (n_done == 0) begin
      errors = errors + 1;
      $display("FAIL %s_timeout: o_done never seen, required within 3000 cycles", name);
    end
  endtask

  task automatic test_reset();
    #3;
    checks = checks + 1;
    if ({o_ctrl_csync_run, o_ctrl_data_run, o_row, o_col, o_chn, o_chn_out, o_is_first_row,
         o_is_last_row, o_is_first_col, o_is_last_col, o_busy, o_done} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: busy=%b row=%0d col=%0d flags=%b, required all 0",
               o_busy, o_row, o_col, {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col});
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (o_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_basic();
    start_layer(3, 4, 2, 1);
    wait_done("basic");
    checks = checks + 4;
    if (n_pix != 24) begin errors++; $display("FAIL basic_pixels: got %0d, required 24", n_pix); end
    if (n_csync_ep != 2) begin errors++; $display("FAIL basic_csync: got %0d episodes, required 2", n_csync_ep); end
    if (n_done != 1) begin errors++; $display("FAIL basic_done: got %0d pulses, required 1", n_done); end
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL basic_end: busy=%b left=%0d, required busy=0 left=0", o_busy, sb.size());
    end
  endtask

  task automatic test_single();
    start_layer(1, 1, 1, 1);
    wait_done("single");
    checks = checks + 2;
    if (n_pix != 1) begin errors++; $display("FAIL single_pixels: got %0d, required 1", n_pix); end
    if (n_done != 1 || sb.size() != 0) begin
      errors++; $display("FAIL single_done: done=%0d left=%0d, required 1 and 0", n_done, sb.size());
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    start_layer(3, 4, 1, 1);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (o_ctrl_data_run && o_row == 1 && o_col == 1) found = 1'b1;
    end
    checks = checks + 1;
    if (!found) begin errors++; $display("FAIL stall_reach: pixel (1,1) not issued, required"); end
    @(posedge clk); #1;
    i_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (o_ctrl_data_run !== 1'b0 || o_row !== 8'd1 || o_col !== 8'd2) begin
        errors++;
        $display("FAIL stall_hold: run=%b r%0d c%0d, required run=0 r1 c2", o_ctrl_data_run, o_row, o_col);
      end
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (o_ctrl_data_run !== 1'b1 || o_row !== 8'd1 || o_col !== 8'd2) begin
      errors++;
      $display("FAIL stall_resume: run=%b r%0d c%0d, required run=1 r1 c2", o_ctrl_data_run, o_row, o_col);
    end
    wait_done("stall");
    checks = checks + 1;
    if (n_pix != 12 || sb.size() != 0) begin
      errors++; $display("FAIL stall_count: got %0d pixels left=%0d, required 12 and 0", n_pix, sb.size());
    end
  endtask

  task automatic test_bad_start();
    clear_stats();
    @(posedge clk); #1;
    cfg_rows = 8'd2; cfg_cols = 8'd0; cfg_q_chn = 4'd1; cfg_q_chn_out = 4'd1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (o_busy !== 1'b0 || o_ctrl_csync_run !== 1'b0) begin
        errors++; $display("FAIL zero_cfg: busy=%b csync=%b, required 0 0", o_busy, o_ctrl_csync_run);
      end
    end
  endtask

  task automatic test_start_in_run();
    bit found = 1'b0;
    start_layer(2, 3, 1, 1);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (o_ctrl_data_run && o_row == 1 && o_col == 0) found = 1'b1;
    end
    @(posedge clk); #1;
    cfg_rows = 8'd1; cfg_cols = 8'd1; cfg_q_chn = 4'd3; cfg_q_chn_out = 4'd3;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done("restart");
    checks = checks + 2;
    if (!found || n_pix != 6 || sb.size() != 0) begin
      errors++; $display("FAIL restart_count: got %0d pixels left=%0d, required 6 and 0", n_pix, sb.size());
    end
    if (n_csync_ep != 1 || n_done != 1) begin
      errors++; $display("FAIL restart_fsm: csync=%0d done=%0d, required 1 1", n_csync_ep, n_done);
    end
  endtask

  task automatic test_reset_mid();
    start_layer(4, 4, 2, 2);
    for (int i = 0; i < 300 && n_pix < 10; i++) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks = checks + 1;
    if ({o_ctrl_csync_run, o_ctrl_data_run, o_row, o_col, o_chn, o_chn_out, o_is_first_row,
         o_is_last_row, o_is_first_col, o_is_last_col, o_busy, o_done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b r%0d c%0d ch%0d co%0d, required all 0",
               o_busy, o_row, o_col, o_chn, o_chn_out);
    end
    sb.delete();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); @(negedge clk);
    checks = checks + 1;
    if (n_done != 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL abort_done: done=%0d busy=%b, required 0 0", n_done, o_busy);
    end
    start_layer(4, 4, 2, 2);
    wait_done("after_abort");
    checks = checks + 2;
    if (n_pix != 64 || sb.size() != 0) begin
      errors++; $display("FAIL abort_relayer: got %0d pixels left=%0d, required 64 and 0", n_pix, sb.size());
    end
    if (n_csync_ep != 4 || n_done != 1) begin
      errors++; $display("FAIL abort_fsm: csync=%0d done=%0d, required 4 1", n_csync_ep, n_done);
    end
  endtask

  task automatic test_csync_hold();
    pe_hold = 1'b1;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: busy=%b, required 0", o_busy); end
    start_layer(2, 2, 2, 2);
    wait_done("hold");
    checks = checks + 3;
    if (n_csync_ep != 4) begin errors++; $display("FAIL hold_episodes: got %0d, required 4", n_csync_ep); end
    if (max_csync_len != 1) begin errors++; $display("FAIL hold_len: got %0d cycles, required 1", max_csync_len); end
    if (n_pix != 16 || n_done != 1) begin
      errors++; $display("FAIL hold_count: pixels=%0d done=%0d, required 16 1", n_pix, n_done);
    end
    pe_hold = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_stall();
    test_bad_start();
    test_start_in_run();
    test_reset_mid();
    test_csync_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
